// File: rtl/bp_axil_stream_pkg.sv
// bp_axil_stream_pkg: shared constants and FSM state types for the AXI-Lite <-> host stream bridge.
// Contents: register map addresses, AXI response codes, write/read FSM state enums.
package bp_axil_stream_pkg;

    localparam logic [31:0] rd_data_addr   = 32'h10;
    localparam logic [31:0] rd_status_addr = 32'h18;

    localparam logic [1:0] resp_okay   = 2'b00;
    localparam logic [1:0] resp_slverr = 2'b10;
    localparam logic [1:0] resp_decerr = 2'b11;

    typedef enum logic [1:0] {
        e_w_idle   = 2'd0,
        e_w_stream = 2'd1,
        e_w_resp   = 2'd2
    } w_state_e;

    typedef enum logic {
        e_r_idle = 1'b0,
        e_r_resp = 1'b1
    } r_state_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// bsg_fifo_1r1w_small: small circular-buffer FIFO with an occupancy count.
// Ports: clk_i/reset_i (sync, active-high); v_i/data_i/ready_o push side (ready_o = not full);
//        v_o/data_o/yumi_i pop side (yumi_i only while v_o); count_o = current occupancy.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 32,
    parameter int els_p   = 4,
    localparam int ptr_w  = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int cnt_w  = $clog2(els_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic [cnt_w-1:0]   count_o
);

    logic [width_p-1:0] r_mem [els_p];
    logic [ptr_w-1:0]   r_wptr, r_rptr;
    logic [cnt_w-1:0]   r_count;
    logic               w_push, w_pop;

    function automatic logic [ptr_w-1:0] nxt(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready depends only on stored occupancy, so a same-cycle pop never frees a full slot early.
    assign ready_o = r_count != cnt_w'(els_p);
    assign v_o     = r_count != '0;
    assign data_o  = r_mem[r_rptr];
    assign count_o = r_count;
    assign w_push  = v_i & ready_o;
    assign w_pop   = yumi_i & v_o;

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= nxt(r_wptr);
            if (w_pop) r_rptr <= nxt(r_rptr);
            r_count <= r_count + cnt_w'(w_push) - cnt_w'(w_pop);
        end
    end

endmodule

// File: rtl/bp_axil_stream_bridge.sv
// bp_axil_stream_bridge: AXI4-Lite slave turning writes into {addr,data} stream beats and serving an inbound stream FIFO via reads.
// Ports: clk_i/reset_i (sync, active-high); s_axil_aw*/w*/b* write channels; s_axil_ar*/r* read channels;
//        stream_v_o/stream_addr_o/stream_data_o/stream_yumi_i outbound beat; stream_v_i/stream_data_i/stream_ready_o inbound beat.
module bp_axil_stream_bridge
    import bp_axil_stream_pkg::*;
#(
    parameter int axil_addr_width_p   = 32,
    parameter int axil_data_width_p   = 32,
    parameter int stream_addr_width_p = 32,
    parameter int stream_data_width_p = 32,
    parameter int rd_fifo_els_p       = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
    input  logic                           s_axil_awvalid_i,
    output logic                           s_axil_awready_o,
    input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
    input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
    input  logic                           s_axil_wvalid_i,
    output logic                           s_axil_wready_o,
    output logic [1:0]                     s_axil_bresp_o,
    output logic                           s_axil_bvalid_o,
    input  logic                           s_axil_bready_i,
    input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
    input  logic                           s_axil_arvalid_i,
    output logic                           s_axil_arready_o,
    output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
    output logic [1:0]                     s_axil_rresp_o,
    output logic                           s_axil_rvalid_o,
    input  logic                           s_axil_rready_i,
    output logic                           stream_v_o,
    output logic [stream_addr_width_p-1:0] stream_addr_o,
    output logic [stream_data_width_p-1:0] stream_data_o,
    input  logic                           stream_yumi_i,
    input  logic                           stream_v_i,
    input  logic [stream_data_width_p-1:0] stream_data_i,
    output logic                           stream_ready_o
);

    localparam int cnt_w = $clog2(rd_fifo_els_p + 1);

    w_state_e                       r_w_state;
    logic                           r_aw_held, r_w_held, r_strb_ok;
    logic [stream_addr_width_p-1:0] r_addr;
    logic [stream_data_width_p-1:0] r_data;
    logic [1:0]                     r_bresp;
    logic                           w_w_idle, w_aw_hs, w_w_hs, w_aw_have, w_w_have, w_strb_ok;

    assign w_w_idle         = r_w_state == e_w_idle;
    assign s_axil_awready_o = w_w_idle & ~r_aw_held;
    assign s_axil_wready_o  = w_w_idle & ~r_w_held;
    assign w_aw_hs          = s_axil_awvalid_i & s_axil_awready_o;
    assign w_w_hs           = s_axil_wvalid_i & s_axil_wready_o;
    // "have" includes a handshake landing this cycle so AW+W together leave idle in one step.
    assign w_aw_have        = r_aw_held | w_aw_hs;
    assign w_w_have         = r_w_held | w_w_hs;
    assign w_strb_ok        = w_w_hs ? &s_axil_wstrb_i : r_strb_ok;
    assign stream_v_o       = r_w_state == e_w_stream;
    assign stream_addr_o    = r_addr;
    assign stream_data_o    = r_data;
    assign s_axil_bvalid_o  = r_w_state == e_w_resp;
    assign s_axil_bresp_o   = r_bresp;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_w_state <= e_w_idle;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_strb_ok <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_bresp   <= resp_okay;
        end else begin
            if (w_aw_hs) r_addr <= s_axil_awaddr_i;
            if (w_w_hs) begin
                r_data    <= s_axil_wdata_i;
                r_strb_ok <= &s_axil_wstrb_i;
            end
            // Hold flags are cleared on leaving idle; being out of idle already blocks new AW/W.
            if (w_w_idle && w_aw_have && w_w_have) begin
                r_w_state <= w_strb_ok ? e_w_stream : e_w_resp;
                r_bresp   <= w_strb_ok ? resp_okay : resp_slverr;
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_held <= 1'b1;
                if (w_w_hs) r_w_held <= 1'b1;
            end
            if (stream_v_o && stream_yumi_i) begin
                r_w_state <= e_w_resp;
                r_bresp   <= resp_okay;
            end
            if (s_axil_bvalid_o && s_axil_bready_i) r_w_state <= e_w_idle;
        end
    end

    r_state_e                     r_r_state;
    logic [axil_data_width_p-1:0] r_rdata;
    logic [1:0]                   r_rresp;
    logic                         w_ar_hs, w_is_data, w_is_stat, w_fifo_v, w_fifo_yumi;
    logic [stream_data_width_p-1:0] w_fifo_data;
    logic [cnt_w-1:0]             w_fifo_count;

    assign s_axil_arready_o = r_r_state == e_r_idle;
    assign s_axil_rvalid_o  = r_r_state == e_r_resp;
    assign s_axil_rdata_o   = r_rdata;
    assign s_axil_rresp_o   = r_rresp;
    assign w_ar_hs          = s_axil_arvalid_i & s_axil_arready_o;
    assign w_is_data        = s_axil_araddr_i == axil_addr_width_p'(rd_data_addr);
    assign w_is_stat        = s_axil_araddr_i == axil_addr_width_p'(rd_status_addr);
    assign w_fifo_yumi      = w_ar_hs & w_is_data & w_fifo_v;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_r_state <= e_r_idle;
            r_rdata   <= '0;
            r_rresp   <= resp_okay;
        end else if (w_ar_hs) begin
            r_r_state <= e_r_resp;
            r_rdata   <= w_is_data ? (w_fifo_v ? w_fifo_data : '0)
                       : w_is_stat ? axil_data_width_p'(w_fifo_count) : '0;
            r_rresp   <= w_is_data ? (w_fifo_v ? resp_okay : resp_slverr)
                       : w_is_stat ? resp_okay : resp_decerr;
        end else if (s_axil_rvalid_o && s_axil_rready_i) begin
            r_r_state <= e_r_idle;
        end
    end

    bsg_fifo_1r1w_small #(
        .width_p(stream_data_width_p),
        .els_p  (rd_fifo_els_p)
    ) u_fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .v_i    (stream_v_i),
        .data_i (stream_data_i),
        .ready_o(stream_ready_o),
        .v_o    (w_fifo_v),
        .data_o (w_fifo_data),
        .yumi_i (w_fifo_yumi),
        .count_o(w_fifo_count)
    );

endmodule

// File: tb/tb_bp_axil_stream_bridge.sv
// tb_bp_axil_stream_bridge: directed bench with a queue-based reference model and a per-cycle compare process.
module tb_bp_axil_stream_bridge;

    localparam int ELS = 4;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] s_axil_awaddr_i, s_axil_wdata_i, s_axil_araddr_i, s_axil_rdata_o;
    logic [3:0]  s_axil_wstrb_i;
    logic        s_axil_awvalid_i, s_axil_awready_o, s_axil_wvalid_i, s_axil_wready_o;
    logic [1:0]  s_axil_bresp_o, s_axil_rresp_o;
    logic        s_axil_bvalid_o, s_axil_bready_i, s_axil_arvalid_i, s_axil_arready_o;
    logic        s_axil_rvalid_o, s_axil_rready_i;
    logic        stream_v_o, stream_yumi_i = 1'b0, stream_v_i, stream_ready_o;
    logic [31:0] stream_addr_o, stream_data_o, stream_data_i;

    int n_cmp = 0, n_fail = 0, yumi_wait = 0, v_cnt = 0;

    logic [63:0] beat_q[$];
    logic [1:0]  bresp_q[$];
    logic [33:0] rd_q[$];
    logic [31:0] fifo_q[$];

    always #5 clk = ~clk;

    bp_axil_stream_bridge dut (
        .clk_i(clk), .reset_i(reset_i),
        .s_axil_awaddr_i(s_axil_awaddr_i), .s_axil_awvalid_i(s_axil_awvalid_i), .s_axil_awready_o(s_axil_awready_o),
        .s_axil_wdata_i(s_axil_wdata_i), .s_axil_wstrb_i(s_axil_wstrb_i), .s_axil_wvalid_i(s_axil_wvalid_i),
        .s_axil_wready_o(s_axil_wready_o), .s_axil_bresp_o(s_axil_bresp_o), .s_axil_bvalid_o(s_axil_bvalid_o),
        .s_axil_bready_i(s_axil_bready_i), .s_axil_araddr_i(s_axil_araddr_i), .s_axil_arvalid_i(s_axil_arvalid_i),
        .s_axil_arready_o(s_axil_arready_o), .s_axil_rdata_o(s_axil_rdata_o), .s_axil_rresp_o(s_axil_rresp_o),
        .s_axil_rvalid_o(s_axil_rvalid_o), .s_axil_rready_i(s_axil_rready_i),
        .stream_v_o(stream_v_o), .stream_addr_o(stream_addr_o), .stream_data_o(stream_data_o),
        .stream_yumi_i(stream_yumi_i), .stream_v_i(stream_v_i), .stream_data_i(stream_data_i),
        .stream_ready_o(stream_ready_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Consumer: accept the outbound beat after it has been visible for yumi_wait cycles.
    always @(posedge clk) begin
        #1;
        if (reset_i || !stream_v_o) begin
            stream_yumi_i = 1'b0;
            v_cnt = 0;
        end else begin
            stream_yumi_i = (v_cnt >= yumi_wait);
            v_cnt++;
        end
    end

    // Reference model + compare, evaluated mid-cycle; handshakes seen here complete at the next posedge.
    always @(negedge clk) begin
        if (reset_i) begin
            beat_q.delete(); bresp_q.delete(); rd_q.delete(); fifo_q.delete();
        end else begin
            chk("stream_ready", stream_ready_o, fifo_q.size() < ELS);
            if (stream_v_o) begin
                if (beat_q.size() == 0) chk("stray_beat", 1, 0);
                else chk("beat_addr_data", {stream_addr_o, stream_data_o}, beat_q[0]);
                if (stream_yumi_i && beat_q.size() != 0) void'(beat_q.pop_front());
            end
            if (s_axil_bvalid_o) begin
                if (bresp_q.size() == 0) chk("stray_bvalid", 1, 0);
                else chk("bresp", s_axil_bresp_o, bresp_q[0]);
                if (s_axil_bready_i && bresp_q.size() != 0) void'(bresp_q.pop_front());
            end
            if (s_axil_rvalid_o) begin
                if (rd_q.size() == 0) chk("stray_rvalid", 1, 0);
                else chk("rresp_rdata", {s_axil_rresp_o, s_axil_rdata_o}, rd_q[0]);
                if (s_axil_rready_i && rd_q.size() != 0) void'(rd_q.pop_front());
            end
            if (s_axil_arvalid_i && s_axil_arready_o) begin
                if (s_axil_araddr_i == 32'h10) begin
                    if (fifo_q.size() > 0) rd_q.push_back({2'b00, fifo_q.pop_front()});
                    else rd_q.push_back({2'b10, 32'h0});
                end else if (s_axil_araddr_i == 32'h18) rd_q.push_back({2'b00, 32'(fifo_q.size())});
                else rd_q.push_back({2'b11, 32'h0});
            end
            if (stream_v_i && stream_ready_o) fifo_q.push_back(stream_data_i);
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int w_lead, output int vc, output logic [1:0] br);
        int t;
        logic a_hs, w_hs;
        vc = 0;
        br = 2'b01;
        if (s == 4'hF) beat_q.push_back({a, d});
        bresp_q.push_back(s == 4'hF ? 2'b00 : 2'b10);
        s_axil_awaddr_i = a; s_axil_wdata_i = d; s_axil_wstrb_i = s;
        s_axil_wvalid_i = 1'b1;
        if (w_lead == 0) s_axil_awvalid_i = 1'b1;
        t = 0;
        while ((s_axil_awvalid_i || s_axil_wvalid_i) && t < 50) begin
            a_hs = s_axil_awvalid_i & s_axil_awready_o;
            w_hs = s_axil_wvalid_i & s_axil_wready_o;
            @(posedge clk); #1; t++;
            if (a_hs) s_axil_awvalid_i = 1'b0;
            if (w_hs) begin
                s_axil_wvalid_i = 1'b0;
                if (w_lead > 0) begin
                    for (int i = 0; i < w_lead; i++) begin
                        chk("lead_awready", s_axil_awready_o, 1);
                        chk("lead_wready", s_axil_wready_o, 0);
                        @(posedge clk); #1;
                    end
                    s_axil_awvalid_i = 1'b1;
                end
            end
        end
        if (t >= 50) begin
            chk("wr_hs_timeout", 1, 0);
            s_axil_awvalid_i = 1'b0; s_axil_wvalid_i = 1'b0;
        end
        t = 0;
        while (t < 50) begin
            if (stream_v_o) vc++;
            if (s_axil_bvalid_o && s_axil_bready_i) begin
                br = s_axil_bresp_o;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1; t++;
        end
        if (t >= 50) chk("bvalid_timeout", 1, 0);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int t;
        logic hs;
        d = 32'hxxxxxxxx;
        r = 2'b01;
        s_axil_araddr_i = a;
        s_axil_arvalid_i = 1'b1;
        t = 0;
        while (s_axil_arvalid_i && t < 50) begin
            hs = s_axil_arready_o;
            @(posedge clk); #1; t++;
            if (hs) s_axil_arvalid_i = 1'b0;
        end
        if (t >= 50) begin
            chk("ar_timeout", 1, 0);
            s_axil_arvalid_i = 1'b0;
        end
        t = 0;
        while (t < 50) begin
            if (s_axil_rvalid_o) begin
                d = s_axil_rdata_o;
                r = s_axil_rresp_o;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1; t++;
        end
        if (t >= 50) chk("rvalid_timeout", 1, 0);
    endtask

    task automatic push(input logic [31:0] d);
        int t;
        logic hs;
        stream_data_i = d;
        stream_v_i = 1'b1;
        t = 0;
        while (stream_v_i && t < 50) begin
            hs = stream_ready_o;
            @(posedge clk); #1; t++;
            if (hs) stream_v_i = 1'b0;
        end
        if (t >= 50) begin
            chk("push_timeout", 1, 0);
            stream_v_i = 1'b0;
        end
    endtask

    initial begin
        int vc, vc2;
        logic [1:0] br, rr;
        logic [31:0] rd;
        reset_i = 1'b1;
        s_axil_awaddr_i = '0; s_axil_awvalid_i = 1'b0; s_axil_wdata_i = '0; s_axil_wstrb_i = '0;
        s_axil_wvalid_i = 1'b0; s_axil_bready_i = 1'b1; s_axil_araddr_i = '0; s_axil_arvalid_i = 1'b0;
        s_axil_rready_i = 1'b1; stream_v_i = 1'b0; stream_data_i = '0;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        chk("rst_awready", s_axil_awready_o, 1);
        chk("rst_wready", s_axil_wready_o, 1);
        chk("rst_arready", s_axil_arready_o, 1);
        chk("rst_valids", {s_axil_bvalid_o, s_axil_rvalid_o, stream_v_o}, 0);
        chk("rst_resp_data", {s_axil_bresp_o, s_axil_rresp_o, s_axil_rdata_o}, 0);
        chk("rst_stream_ready", stream_ready_o, 1);

        yumi_wait = 2;
        do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, vc, br);
        chk("t1_beat_cycles", vc, 3);
        chk("t1_bresp", br, 2'b00);

        yumi_wait = 0;
        do_write(32'h20, 32'h1234, 4'hF, 5, vc, br);
        chk("t2_beat_cycles", vc, 1);
        chk("t2_bresp", br, 2'b00);

        do_write(32'h30, 32'h5555, 4'h3, 0, vc, br);
        chk("t3_beat_cycles", vc, 0);
        chk("t3_bresp", br, 2'b10);

        for (int i = 1; i <= 4; i++) push(32'(i));
        chk("t4_full_ready", stream_ready_o, 0);
        do_read(32'h18, rd, rr);
        chk("t4_status", {rr, rd}, {2'b00, 32'd4});
        for (int i = 1; i <= 4; i++) begin
            do_read(32'h10, rd, rr);
            chk("t4_pop", {rr, rd}, {2'b00, 32'(i)});
        end
        do_read(32'h10, rd, rr);
        chk("t4_empty_pop", {rr, rd}, {2'b10, 32'h0});

        yumi_wait = 1;
        fork
            do_read(32'h44, rd, rr);
            do_write(32'h40, 32'hCAFEF00D, 4'hF, 0, vc2, br);
        join
        chk("t5_decerr", {rr, rd}, {2'b11, 32'h0});
        chk("t5_beat_cycles", vc2, 2);
        chk("t5_bresp", br, 2'b00);

        push(32'hA);
        push(32'hB);
        s_axil_bready_i = 1'b0;
        yumi_wait = 1000;
        chk("t6_awready_pre", s_axil_awready_o, 1);
        beat_q.push_back({32'h60, 32'h66});
        s_axil_awaddr_i = 32'h60; s_axil_wdata_i = 32'h66; s_axil_wstrb_i = 4'hF;
        s_axil_awvalid_i = 1'b1; s_axil_wvalid_i = 1'b1;
        @(posedge clk); #1;
        s_axil_awvalid_i = 1'b0; s_axil_wvalid_i = 1'b0;
        @(posedge clk); #1;
        chk("t6_in_stream", stream_v_o, 1);
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        chk("t6_stream_v", stream_v_o, 0);
        chk("t6_bvalid", s_axil_bvalid_o, 0);
        chk("t6_awready", s_axil_awready_o, 1);
        chk("t6_stream_ready", stream_ready_o, 1);
        do_read(32'h18, rd, rr);
        chk("t6_count", {rr, rd}, {2'b00, 32'd0});
        s_axil_bready_i = 1'b1;
        yumi_wait = 0;
        do_write(32'h50, 32'h77, 4'hF, 0, vc, br);
        chk("t6_recover_beat", vc, 1);
        chk("t6_recover_bresp", br, 2'b00);

        repeat (2) @(posedge clk);
        chk("end_beats_left", beat_q.size(), 0);
        chk("end_bresps_left", bresp_q.size(), 0);
        chk("end_reads_left", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
